// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ready, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to data memory, stalls upstream while
// the memory is busy, and registers the MEM/WB outputs.
module mem_stage #(
  // Reset value of stall_count; left at 0 except to exercise saturation quickly.
  parameter logic [31:0] STALL_CNT_PRELOAD = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ex_ALU_result,
  input  logic [63:0] ex_Db,
  input  logic [4:0]  ex_Rd,
  input  logic        ex_mem_wr,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_to_reg,
  input  logic [31:0] ex_instruction,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_Rd,
  output logic        wb_reg_wr,
  output logic [31:0] wb_instruction,
  output logic [31:0] stall_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        load;
    logic [31:0] instr;
  } hold_t;

  state_t state, state_nx;
  hold_t  hold, cur, sel;
  logic   memop, store, load, req;

  assign memop = ex_mem_wr | ex_mem_to_reg;
  assign store = ex_mem_wr;
  assign load  = ex_mem_to_reg & ~ex_mem_wr;

  assign cur = '{addr: ex_ALU_result, wdata: ex_Db, we: store, rd: ex_Rd,
                 reg_wr: ex_reg_wr, load: load, instr: ex_instruction};
  // Once waiting, the EX/MEM inputs are stale; everything comes from the hold copy.
  assign sel = (state == WAIT) ? hold : cur;

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    stall    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (memop) begin
          req = 1'b1;
          if (!dmem.dmem_ready) begin
            stall    = 1'b1;
            state_nx = WAIT;
          end
        end
        WAIT: begin
          req = 1'b1;
          if (dmem.dmem_ready) state_nx = IDLE;
          else                 stall    = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    dmem.dmem_req   = req;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
    if (req) begin
      dmem.dmem_we    = sel.we;
      dmem.dmem_addr  = sel.addr;
      dmem.dmem_wdata = sel.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold           <= '0;
      wb_data        <= '0;
      wb_Rd          <= '0;
      wb_reg_wr      <= 1'b0;
      wb_instruction <= '0;
      stall_count    <= STALL_CNT_PRELOAD;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == WAIT) hold <= cur;
      if (stall) begin
        wb_data        <= '0;
        wb_Rd          <= '0;
        wb_reg_wr      <= 1'b0;
        wb_instruction <= '0;
        if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
      end else begin
        wb_data        <= sel.load ? dmem.dmem_rdata : sel.addr;
        wb_Rd          <= sel.rd;
        // Register 31 is XZR: writes to it are dropped.
        wb_reg_wr      <= sel.reg_wr & (sel.rd != 5'd31);
        wb_instruction <= sel.instr;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] ex_ALU_result, ex_Db;
  logic [4:0]  ex_Rd;
  logic        ex_mem_wr, ex_reg_wr, ex_mem_to_reg;
  logic [31:0] ex_instruction;

  logic        stall, s_stall;
  logic [63:0] wb_data, s_wb_data;
  logic [4:0]  wb_Rd, s_wb_Rd;
  logic        wb_reg_wr, s_wb_reg_wr;
  logic [31:0] wb_instruction, s_wb_instruction;
  logic [31:0] stall_count, s_stall_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = '0;

  mem_stage_if dif();
  mem_stage_if sif();
  assign sif.dmem_ready = dif.dmem_ready;
  assign sif.dmem_rdata = dif.dmem_rdata;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_ALU_result(ex_ALU_result), .ex_Db(ex_Db), .ex_Rd(ex_Rd),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_instruction(ex_instruction), .dmem(dif.master), .stall(stall),
    .wb_data(wb_data), .wb_Rd(wb_Rd), .wb_reg_wr(wb_reg_wr),
    .wb_instruction(wb_instruction), .stall_count(stall_count)
  );

  // Second copy with a preloaded counter, sharing all stimulus, for saturation.
  mem_stage #(.STALL_CNT_PRELOAD(32'hFFFF_FFF0)) u_sat (
    .clk(clk), .rst(rst),
    .ex_ALU_result(ex_ALU_result), .ex_Db(ex_Db), .ex_Rd(ex_Rd),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_instruction(ex_instruction), .dmem(sif.master), .stall(s_stall),
    .wb_data(s_wb_data), .wb_Rd(s_wb_Rd), .wb_reg_wr(s_wb_reg_wr),
    .wb_instruction(s_wb_instruction), .stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic garbage_ex();
    ex_ALU_result  = {$urandom, $urandom};
    ex_Db          = {$urandom, $urandom};
    ex_Rd          = 5'($urandom);
    ex_mem_wr      = 1'($urandom);
    ex_mem_to_reg  = 1'($urandom);
    ex_reg_wr      = 1'($urandom);
    ex_instruction = $urandom;
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = both flags set (acts as store)
  task automatic do_txn(input string name, input int kind, input logic [63:0] alu,
                        input logic [63:0] db, input logic [4:0] rd, input logic regwr,
                        input logic [31:0] instr, input int nwait_in, input logic [63:0] rdata);
    logic memop, is_store, is_load, exp_rw;
    logic [63:0] exp_data;
    logic [130:0] got_bus, exp_bus;
    logic [101:0] got_wb, exp_wb;
    int nwait;
    memop    = (kind != 0);
    is_store = kind[1];
    is_load  = (kind == 1);
    nwait    = memop ? nwait_in : 0;
    exp_data = is_load ? rdata : alu;
    exp_rw   = regwr && (rd != 5'd31);
    for (int c = 0; c <= nwait; c++) begin
      if (c == 0) begin
        ex_ALU_result = alu; ex_Db = db; ex_Rd = rd; ex_reg_wr = regwr;
        ex_mem_wr = kind[1]; ex_mem_to_reg = kind[0]; ex_instruction = instr;
      end else garbage_ex();
      dif.dmem_ready = (c == nwait);
      dif.dmem_rdata = (c == nwait) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      exp_bus = {memop, memop & is_store, memop ? alu : 64'h0, memop ? db : 64'h0,
                 memop && (c < nwait)};
      got_bus = {dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, stall};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL %s req/we/addr/wdata/stall cycle %0d: got %h expected %h",
                 name, c, got_bus, exp_bus);
      end
      @(posedge clk); #1;
      exp_wb = (c < nwait) ? '0 : {exp_data, rd, exp_rw, instr};
      got_wb = {wb_data, wb_Rd, wb_reg_wr, wb_instruction};
      checks++;
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL %s mem/wb cycle %0d: got %h expected %h", name, c, got_wb, exp_wb);
      end
    end
    model_cnt = (32'hFFFF_FFFF - model_cnt < 32'(nwait)) ? 32'hFFFF_FFFF : model_cnt + 32'(nwait);
    checks++;
    if (stall_count !== model_cnt) begin
      errors++;
      $display("FAIL %s stall_count: got %0d expected %0d", name, stall_count, model_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    garbage_ex();
    ex_mem_to_reg = 1'b1;
    dif.dmem_ready = 1'b0;
    dif.dmem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({dif.dmem_req, stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset req/stall forced low: got %b expected 00", {dif.dmem_req, stall});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = '0;
    checks++;
    if ({wb_data, wb_Rd, wb_reg_wr, wb_instruction, stall_count} !== 134'h0) begin
      errors++;
      $display("FAIL reset state: got %h expected 0",
               {wb_data, wb_Rd, wb_reg_wr, wb_instruction, stall_count});
    end
  endtask

  task automatic test_pass_through();
    do_txn("pass_through", 0, 64'h1234, 64'h9, 5'd5, 1'b1, 32'h8B02_0025, 0, 64'h0);
  endtask

  task automatic test_zero_wait_load();
    do_txn("zero_wait_load", 1, 64'h40, 64'h77, 5'd7, 1'b1, 32'hF840_0047, 0, 64'hDEAD_BEEF);
  endtask

  task automatic test_store_wait3();
    do_txn("store_wait3", 2, 64'h80, 64'h55, 5'd3, 1'b0, 32'hF800_0083, 3, 64'h0);
    checks++;
    if (stall_count !== 32'd3) begin
      errors++;
      $display("FAIL store_wait3 total stalls: got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_xzr();
    do_txn("xzr_write", 0, 64'hABCD, 64'h0, 5'd31, 1'b1, 32'h8B1F_03FF, 0, 64'h0);
    do_txn("both_flags", 3, 64'h100, 64'hCAFE, 5'd9, 1'b1, 32'h1234_5678, 1, 64'h1111);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_txn("random", int'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 4)),
             {$urandom, $urandom});
  endtask

  task automatic test_reset_mid_wait();
    ex_ALU_result = 64'h200; ex_Db = '0; ex_Rd = 5'd4; ex_reg_wr = 1'b1;
    ex_mem_wr = 1'b0; ex_mem_to_reg = 1'b1; ex_instruction = 32'hF840_0204;
    dif.dmem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    garbage_ex();
    @(negedge clk);
    checks++;
    if ({dif.dmem_req, stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_wait req/stall in reset: got %b expected 00", {dif.dmem_req, stall});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = '0;
    ex_ALU_result = '0; ex_Db = '0; ex_Rd = '0; ex_reg_wr = 1'b0;
    ex_mem_wr = 1'b0; ex_mem_to_reg = 1'b0; ex_instruction = '0;
    dif.dmem_ready = 1'b1;
    dif.dmem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, stall} !== 131'h0) begin
      errors++;
      $display("FAIL reset_mid_wait late ready: got %h expected 0",
               {dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, stall});
    end
    @(posedge clk); #1;
    checks++;
    if ({wb_data, wb_Rd, wb_reg_wr, wb_instruction, stall_count} !== 134'h0) begin
      errors++;
      $display("FAIL reset_mid_wait mem/wb+count: got %h expected 0",
               {wb_data, wb_Rd, wb_reg_wr, wb_instruction, stall_count});
    end
  endtask

  task automatic test_saturation();
    checks++;
    if (s_stall_count !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL saturation preload: got %h expected fffffff0", s_stall_count);
    end
    do_txn("sat_long_wait", 1, 64'h300, 64'h0, 5'd2, 1'b1, 32'h1, 20, 64'h5A5A);
    checks++;
    if (s_stall_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL saturation after 20 stalls: got %h expected ffffffff", s_stall_count);
    end
    do_txn("sat_hold", 2, 64'h308, 64'h1, 5'd2, 1'b0, 32'h2, 2, 64'h0);
    checks++;
    if (s_stall_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL saturation no wrap: got %h expected ffffffff", s_stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_zero_wait_load();
    test_store_wait3();
    test_xzr();
    test_random();
    test_reset_mid_wait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, reset, synchronous and active-high, sampled on the clk rising edge.
REQ-003 SHALL have the EX/MEM register inputs: ex_ALU_result in 64; ex_Db in 64; ex_Rd in 5; ex_mem_wr in 1; ex_reg_wr in 1; ex_mem_to_reg in 1; ex_instruction in 32.
REQ-004 SHALL have the data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 64; dmem_wdata out 64; dmem_ready in 1 (access complete); dmem_rdata in 64 (valid when dmem_ready=1 on a load).
REQ-005 SHALL have stall, out, 1: upstream stages hold when it is 1.
REQ-006 SHALL have the MEM/WB outputs: wb_data out 64; wb_Rd out 5; wb_reg_wr out 1; wb_instruction out 32.
REQ-007 SHALL have stall_count, out, 32: saturating count of stalled cycles.

Function
REQ-008 SHALL define memop = ex_mem_wr | ex_mem_to_reg.
REQ-009 SHALL define store = ex_mem_wr, which takes priority when ex_mem_wr and ex_mem_to_reg are both 1.
REQ-010 SHALL define load = ex_mem_to_reg & ~ex_mem_wr.
REQ-011 SHALL implement an FSM with two states, IDLE and WAIT.
REQ-012 SHALL, in IDLE with memop=1, drive these combinationally from the current inputs: dmem_req=1, dmem_we=store, dmem_addr=ex_ALU_result, dmem_wdata=ex_Db.
REQ-013 SHALL, in IDLE with memop=1 and dmem_ready=1, complete a zero-wait access: no stall, MEM/WB loads at the next edge, FSM stays IDLE.
REQ-014 SHALL, in IDLE with memop=1 and dmem_ready=0, assert stall=1 and move to WAIT.
REQ-015 SHALL, on the IDLE-to-WAIT transition, latch addr, wdata, we, Rd, reg_wr, load flag and instruction into internal hold registers.
REQ-016 SHALL, in WAIT, drive dmem_req=1 and drive dmem_addr, dmem_wdata and dmem_we from the hold registers; ex_* inputs are ignored.
REQ-017 SHALL, in WAIT with dmem_ready=0, keep stall=1 and stay in WAIT, with no limit on wait length.
REQ-018 SHALL, in WAIT with dmem_ready=1, drive stall=0, load MEM/WB from the hold registers at the next edge, and return to IDLE.
REQ-019 SHALL, in IDLE with memop=0, drive dmem_req=0 and stall=0 and load MEM/WB from the inputs at the next edge: a 1-cycle pass-through.
REQ-020 SHALL select wb_data as dmem_rdata for a load and as the ALU result (input or held) otherwise.
REQ-021 SHALL set wb_reg_wr = reg_wr & (Rd != 31), so that writes to XZR are suppressed; wb_Rd and wb_instruction still pass through unchanged.
REQ-022 SHALL load MEM/WB with a bubble on every edge where stall=1: wb_reg_wr=0, wb_data=0, wb_Rd=0, wb_instruction=0.
REQ-023 SHALL drive dmem_we=0, dmem_addr=0 and dmem_wdata=0 when dmem_req=0.
REQ-024 SHALL increment stall_count on every edge where stall=1, saturating at 0xFFFFFFFF with no wrap.
REQ-025 SHALL make stall a combinational function of the FSM state, memop and dmem_ready only.
REQ-026 SHALL have a latency of 1 cycle from input to MEM/WB when there is no wait, or N+1 cycles for N wait cycles.

Reset
REQ-027 SHALL, while rst=1 at an edge, set: FSM=IDLE; hold registers=0; wb_data=0; wb_Rd=0; wb_reg_wr=0; wb_instruction=0; stall_count=0.
REQ-028 SHALL, while rst=1, force dmem_req=0 and stall=0 combinationally, overriding REQ-012 to REQ-018.
REQ-029 SHALL, when reset is asserted in WAIT, abandon the access: no MEM/WB update from it and IDLE on the next cycle; a late dmem_ready arriving while in IDLE with memop=0 is ignored.

Verification
REQ-030 SHALL verify ALU pass-through: ex_ALU_result=0x1234, ex_Rd=5, ex_reg_wr=1, memop=0 -> next cycle wb_data=0x1234, wb_Rd=5, wb_reg_wr=1; dmem_req=0 and stall=0 throughout.
REQ-031 SHALL verify a zero-wait load: ex_mem_to_reg=1, ex_ALU_result=0x40, dmem_ready=1 same cycle with dmem_rdata=0xDEADBEEF -> dmem_addr=0x40 and dmem_we=0 that cycle; next cycle wb_data=0xDEADBEEF; stall never 1.
REQ-032 SHALL verify a 3-wait store: ex_mem_wr=1, addr=0x80, Db=0x55, then ex_* changed to garbage, dmem_ready=1 on the 4th cycle -> stall=1 for exactly 3 cycles, dmem_addr=0x80 and dmem_wdata=0x55 held throughout, three bubbles on MEM/WB, stall_count=3.
REQ-033 SHALL verify the XZR write: ex_Rd=31, ex_reg_wr=1, memop=0 -> wb_reg_wr=0, wb_Rd=31; also both ex_mem_wr=1 and ex_mem_to_reg=1 -> dmem_we=1 and wb_data=ALU result.
REQ-034 SHALL verify reset mid-WAIT: load enters WAIT, rst=1 for one cycle, dmem_ready=1 one cycle later with memop=0 -> FSM IDLE, MEM/WB all 0, stall=0, stall_count=0, no load data captured.
REQ-035 SHALL verify saturation: stall_count forced via a long wait of 2^32+2 cycles, or a test preload -> stall_count stays at 0xFFFFFFFF.
